// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: sizes, Rcon table, FSM states and word type.
package aes_pkg;

    localparam int unsigned NK = 8;
    localparam int unsigned NR = 14;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StExpand,
        StFinish
    } state_t;

    // Index 0 is never used; i/8 runs 1..7 for AES-256.
    localparam logic [7:0] RCON [8] = '{8'h00, 8'h01, 8'h02, 8'h04,
                                        8'h08, 8'h10, 8'h20, 8'h40};

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/mod_sbox_word.sv
// SubWord: four parallel AES S-box lookups on a 32-bit word, purely combinational.
module mod_sbox_word
    import aes_pkg::*;
(
    input  logic [31:0] din,
    output logic [31:0] dout
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    always_comb begin
        dout = '0;
        for (int i = 0; i < 4; i++) begin
            dout[8*i +: 8] = SBOX[din[8*i +: 8]];
        end
    end

endmodule

// File: rtl/mod_key_expansion.sv
// AES-256 key expansion, one word per cycle, streaming round keys to a key store.
// Define KEYEXP_REVERSE_EN to write round key k at address NR-k (decryption order).
module mod_key_expansion
    import aes_pkg::*;
#(
    parameter int unsigned NR     = 14,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [255:0]      key,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    // The word counter doubles as the LOAD phase timer: 6, 7, then 8..59 in EXPAND.
    localparam logic [5:0] LOAD_CNT  = 6'(NK - 2);
    localparam logic [5:0] LAST_WORD = 6'(4 * (NR + 1) - 1);

    state_t            state_q, state_d;
    word_t             win_q [NK];
    word_t             win_d [NK];
    logic [5:0]        cnt_q, cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              done_q, done_d;

    word_t sub_in, sub_out, temp, new_word;

    function automatic logic [ADDR_W-1:0] key_addr(input logic [3:0] k);
`ifdef KEYEXP_REVERSE_EN
        return ADDR_W'(NR - 32'(k));
`else
        return ADDR_W'(k);
`endif
    endfunction

    mod_sbox_word u_sbox (
        .din  (sub_in),
        .dout (sub_out)
    );

    always_comb begin
        sub_in = (cnt_q[2:0] == 3'd0) ? rot_word(win_q[NK-1]) : win_q[NK-1];
        temp   = win_q[NK-1];
        if (cnt_q[2:0] == 3'd0) begin
            temp = sub_out ^ {RCON[cnt_q[5:3]], 24'h000000};
        end else if (cnt_q[2:0] == 3'd4) begin
            temp = sub_out;
        end
        new_word = win_q[0] ^ temp;
    end

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    for (int j = 0; j < NK; j++) begin
                        win_d[j] = key[255-32*j -: 32];
                    end
                    cnt_d     = LOAD_CNT;
                    wr_en_d   = 1'b1;
                    wr_addr_d = key_addr(4'd0);
                    wr_data_d = key[255:128];
                end
            end
            StLoad: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LOAD_CNT) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = key_addr(4'd1);
                    wr_data_d = {win_q[4], win_q[5], win_q[6], win_q[7]};
                end else begin
                    state_d = StExpand;
                end
            end
            StExpand: begin
                for (int j = 0; j < NK - 1; j++) begin
                    win_d[j] = win_q[j+1];
                end
                win_d[NK-1] = new_word;
                cnt_d       = cnt_q + 6'd1;
                // Last word of a round key: the three before it are still in the window.
                if (cnt_q[1:0] == 2'd3) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = key_addr(cnt_q[5:2]);
                    wr_data_d = {win_q[5], win_q[6], win_q[7], new_word};
                end
                if (cnt_q == LAST_WORD) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                state_d = StIdle;
                done_d  = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            for (int j = 0; j < NK; j++) begin
                win_q[j] <= '0;
            end
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = (state_q != StIdle);
    assign done    = done_q;

endmodule

// File: tb/tb_mod_key_expansion.sv
// Scoreboarded bench for mod_key_expansion against an independent AES-256 key-schedule model.
module tb_mod_key_expansion;

    localparam int NR     = 14;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 128;

    localparam logic [255:0] KEY_A3 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] A3_K2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
    localparam logic [127:0] A3_K14 = 128'hfe4890d1e6188d0b046df344706c631e;
    localparam logic [127:0] Z_K2   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z_K3   = 128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [255:0]      key = '0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;

    mod_key_expansion #(
        .NR     (NR),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .key     (key),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           c;
        logic [3:0]   addr;
        logic [127:0] data;
    } wr_t;

    wr_t          wr_q [$];
    int           done_q [$];
    int           total = 0;
    int           bad = 0;
    int           run_start = 1;
    int           run_end = 0;
    logic [127:0] seen_data [16];
    int           seen_cyc [16];
    logic [7:0]   sbox [256];
    logic [31:0]  mw [60];

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box derived from GF(2^8) inversion plus the affine map.
    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[x] = s;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic model_expand(input logic [255:0] k);
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 8; i++) mw[i] = k[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = mw[i-1];
            if (i % 8 == 0) begin
                rc = 8'h01 << (i / 8 - 1);
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            mw[i] = mw[i-8] ^ t;
        end
    endtask

    function automatic int addr_of(input int k);
`ifdef KEYEXP_REVERSE_EN
        return NR - k;
`else
        return k;
`endif
    endfunction

    task automatic launch(input logic [255:0] k, input int t, input int nkeys,
                          input bit with_done);
        wr_t e;
        model_expand(k);
        for (int kk = 0; kk < nkeys; kk++) begin
            e.c    = (kk == 0) ? t + 1 : (kk == 1) ? t + 2 : t + 4 * kk - 1;
            e.addr = 4'(addr_of(kk));
            e.data = {mw[4*kk], mw[4*kk+1], mw[4*kk+2], mw[4*kk+3]};
            wr_q.push_back(e);
        end
        if (with_done) done_q.push_back(t + 56);
        run_start = t + 1;
        run_end   = t + 55;
    endtask

    // Called at a negedge: start is sampled by the next posedge, so this cycle is T.
    task automatic start_run(input logic [255:0] k, input int nkeys, input bit with_done,
                             output int t);
        t     = cyc;
        start = 1'b1;
        key   = k;
        launch(k, t, nkeys, with_done);
        @(negedge clk);
        start = 1'b0;
    endtask

    always @(negedge clk) begin
        wr_t  e;
        logic exp_busy;
        exp_busy = (cyc >= run_start && cyc <= run_end);
        total++;
        assert (busy === exp_busy) else begin
            bad++;
            $error("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
        end
        total++;
        assert (!(busy === 1'b1 && done === 1'b1)) else begin
            bad++;
            $error("FAIL busy_and_done cyc=%0d got=both exp=not_both", cyc);
        end
        while (wr_q.size() > 0 && wr_q[0].c < cyc) begin
            e = wr_q.pop_front();
            total++;
            bad++;
            $error("FAIL missing_write got=none exp=addr%0d@cyc%0d", e.addr, e.c);
        end
        while (done_q.size() > 0 && done_q[0] < cyc) begin
            total++;
            bad++;
            $error("FAIL missing_done got=none exp=cyc%0d", done_q.pop_front());
        end
        if (wr_en === 1'b1) begin
            if (wr_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_write cyc=%0d got=addr%0d exp=no_write", cyc, wr_addr);
            end else begin
                e = wr_q.pop_front();
                total++;
                assert (cyc == e.c) else begin
                    bad++;
                    $error("FAIL write_cycle got=%0d exp=%0d", cyc, e.c);
                end
                total++;
                assert (wr_addr === e.addr) else begin
                    bad++;
                    $error("FAIL write_addr cyc=%0d got=%0d exp=%0d", cyc, wr_addr, e.addr);
                end
                total++;
                assert (wr_data === e.data) else begin
                    bad++;
                    $error("FAIL write_data cyc=%0d got=%h exp=%h", cyc, wr_data, e.data);
                end
                seen_data[wr_addr] = wr_data;
                seen_cyc[wr_addr]  = cyc;
            end
        end else if (wr_en !== 1'b0) begin
            total++;
            bad++;
            $error("FAIL wr_en_x cyc=%0d got=%b exp=0/1", cyc, wr_en);
        end
        if (done === 1'b1) begin
            if (done_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_done got=cyc%0d exp=none", cyc);
            end else begin
                total++;
                assert (cyc == done_q[0]) else begin
                    bad++;
                    $error("FAIL done_cycle got=%0d exp=%0d", cyc, done_q[0]);
                end
                void'(done_q.pop_front());
            end
        end
    end

    task automatic check_key(input string tag, input int k, input int t,
                             input logic [127:0] exp_data, input int exp_off);
        int a;
        a = addr_of(k);
        total++;
        assert (seen_data[a] === exp_data) else begin
            bad++;
            $error("FAIL %s data got=%h exp=%h", tag, seen_data[a], exp_data);
        end
        total++;
        assert (seen_cyc[a] == t + exp_off) else begin
            bad++;
            $error("FAIL %s cycle got=%0d exp=%0d", tag, seen_cyc[a], t + exp_off);
        end
    endtask

    initial begin
        int           t, t0;
        logic [255:0] rk;

        build_sbox();
        for (int i = 0; i < 16; i++) begin
            seen_data[i] = '0;
            seen_cyc[i]  = -1;
        end

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        assert (wr_en === 1'b0) else begin bad++; $error("FAIL rst_wr_en got=%b exp=0", wr_en); end
        total++;
        assert (wr_addr === '0) else begin bad++; $error("FAIL rst_addr got=%0d exp=0", wr_addr); end
        total++;
        assert (wr_data === '0) else begin bad++; $error("FAIL rst_data got=%h exp=0", wr_data); end
        total++;
        assert (busy === 1'b0) else begin bad++; $error("FAIL rst_busy got=%b exp=0", busy); end
        total++;
        assert (done === 1'b0) else begin bad++; $error("FAIL rst_done got=%b exp=0", done); end

        // FIPS-197 A.3 vector, started on the first cycle out of reset
        rst = 1'b0;
        start_run(KEY_A3, 15, 1'b1, t);
        repeat (60) @(negedge clk);
        check_key("a3_key2", 2, t, A3_K2, 7);
        check_key("a3_key14", 14, t, A3_K14, 55);

        // All-zero key
        start_run('0, 15, 1'b1, t);
        repeat (60) @(negedge clk);
        check_key("zero_key2", 2, t, Z_K2, 7);
        check_key("zero_key3", 3, t, Z_K3, 11);

        // Key changes and start pulses mid-run must not disturb the run
        rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        start_run(rk, 15, 1'b1, t);
        repeat (4) @(negedge clk);
        key = ~rk;
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);

        // Reset at T+20 aborts after key 5; restart right after reset
        rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        start_run(rk, 6, 1'b0, t);
        repeat (19) @(negedge clk);
        rst     = 1'b1;
        run_end = t + 20;
        @(negedge clk);
        rst = 1'b0;
        total++;
        assert (busy === 1'b0) else begin bad++; $error("FAIL abort_busy got=%b exp=0", busy); end
        total++;
        assert (wr_addr === '0) else begin bad++; $error("FAIL abort_addr got=%0d exp=0", wr_addr); end
        total++;
        assert (wr_data === '0) else begin bad++; $error("FAIL abort_data got=%h exp=0", wr_data); end
        start_run(KEY_A3, 15, 1'b1, t);
        repeat (60) @(negedge clk);
        check_key("restart_key14", 14, t, A3_K14, 55);

        // Start held high for 200 cycles: runs every 56 cycles
        rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        t0    = cyc;
        start = 1'b1;
        key   = rk;
        for (int r = 0; r < 3; r++) begin
            launch(rk, t0 + 56 * r, 15, 1'b1);
            repeat (56) @(negedge clk);
        end
        launch(rk, t0 + 168, 15, 1'b1);
        repeat (32) @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);

        total++;
        assert (wr_q.size() == 0) else begin
            bad++;
            $error("FAIL pending_writes got=%0d exp=0", wr_q.size());
        end
        total++;
        assert (done_q.size() == 0) else begin
            bad++;
            $error("FAIL pending_done got=%0d exp=0", done_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
